instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
- Front end of the yarp RV32I core; the consumer of the branch decision and the producer of the instructions that decode and branch evaluation work on.
- Holds the program counter and issues word fetches to instruction memory over a req/gnt/rvalid handshake.
- Presents fetched instructions to decode through a valid/ready output register.
- Redirects on a taken branch or jump, killing any wrong-path fetch in flight.

Parameters:
- RESET_PC, 32'h0000_1000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  input  1  core clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- redirect_i  input  1  taken branch or jump resolved this cycle
- redirect_pc_i  input  32  redirect target; bits [1:0] ignored, forced to 0
- imem_req_o  output  1  fetch request valid
- imem_addr_o  output  32  fetch word address
- imem_gnt_i  input  1  memory accepts request this cycle
- imem_rvalid_i  input  1  read data valid, exactly once per granted request, at least 1 cycle after gnt
- imem_rdata_i  input  32  instruction word
- instr_valid_o  output  1  instruction register holds a valid instruction
- instr_o  output  32  fetched instruction
- instr_pc_o  output  32  PC of instr_o
- instr_ready_i  input  1  decode accepts instruction

Behaviour:
- Reset:
  - pc = RESET_PC, state = REQ, kill = 0.
  - instr_valid_o = 0; instr_o = 32'h0000_0013 (NOP); instr_pc_o = 0.
  - imem_req_o is forced to 0 while reset is high.
- Outputs:
  - imem_req_o = (state == REQ); imem_addr_o = pc.
  - instr_* are registered outputs.
- At most one request is outstanding at any time.
- REQ state:
  - With imem_gnt_i: req_pc <= pc, pc <= pc + 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), go to WAIT.
  - With redirect_i and no gnt: pc <= target; stay in REQ. The address changes next cycle; the request is retargeted before it is granted.
  - With redirect_i and gnt in the same cycle: the request is granted at the old pc. Set kill, pc <= target, go to WAIT.
- WAIT state:
  - On imem_rvalid_i with kill = 0: instr_o <= imem_rdata_i, instr_pc_o <= req_pc, instr_valid_o <= 1, go to HOLD.
  - On imem_rvalid_i with kill = 1: discard the data, clear kill, go to REQ.
  - On redirect_i without rvalid: set kill, pc <= target.
  - On redirect_i in the same cycle as rvalid: discard the data, pc <= target, go to REQ with kill = 0.
- HOLD state:
  - On instr_ready_i: instr_valid_o <= 0, go to REQ.
  - On redirect_i: instr_valid_o <= 0, pc <= target, go to REQ. Redirect wins over a simultaneous instr_ready_i.
  - The consumer qualifies any acceptance with !redirect_i.
- Multiple redirects: the latest redirect_pc_i before the next grant wins. kill stays set until the single pending response drains.
- Latency:
  - Redirect in cycle t from REQ or HOLD: imem_req_o with the target address in cycle t+1.
  - rvalid in cycle t (unkilled): instr_valid_o = 1 in cycle t+1.
  - Handshake in cycle t: next imem_req_o in cycle t+1.
- While imem_req_o = 1 and no redirect occurs, imem_addr_o stays stable until gnt.
- Reset mid-operation: all state returns to the reset values on the next edge. A memory response to a pre-reset request must not arrive after reset; this is a system-level guarantee.

Test Plan:
- Reset release, gnt tied 1, rvalid 1 cycle after gnt, ready tied 1 -> addresses 0x1000, 0x1004, 0x1008 are fetched. instr_pc_o matches each instruction, and no instruction is duplicated or dropped.
- gnt held low 3 cycles at pc 0x1004 -> imem_addr_o stays 0x1004 throughout; after gnt the next address is 0x1008.
- ready low 4 cycles while in HOLD -> instr_o and instr_pc_o stay stable and no new request is issued; on ready, a request follows the next cycle.
- Redirect to 0x2002 while in WAIT, rvalid 2 cycles later -> the response is discarded, instr_valid_o stays 0, and the next request goes to 0x2000.
- Redirect together with ready in HOLD, target 0x3000 -> instr_valid_o = 0 next cycle and the request goes to 0x3000.
- Redirect with gnt in the same REQ cycle, then a second redirect to 0x4000 during WAIT -> the old-pc response is discarded and the request goes to 0x4000.
- pc 0xFFFF_FFFC granted -> the next request address is 0x0000_0000.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch front end: owns the PC, fetches one word at a time over req/gnt/rvalid,
// and holds the fetched instruction in a valid/ready register for decode.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        kill_q, kill_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] target;

  assign target = redirect_pc_i & 32'hFFFF_FFFC;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    kill_d        = kill_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    case (state_q)
      StReq: begin
        if (imem_gnt_i) begin
          // A redirect in the grant cycle still lets the old-pc request go; its data is killed.
          req_pc_d = pc_q;
          pc_d     = redirect_i ? target : pc_q + 32'd4;
          kill_d   = redirect_i;
          state_d  = StWait;
        end else if (redirect_i) begin
          pc_d = target;
        end
      end
      StWait: begin
        if (imem_rvalid_i) begin
          kill_d = 1'b0;
          if (redirect_i) begin
            pc_d    = target;
            state_d = StReq;
          end else if (kill_q) begin
            state_d = StReq;
          end else begin
            instr_d       = imem_rdata_i;
            instr_pc_d    = req_pc_q;
            instr_valid_d = 1'b1;
            state_d       = StHold;
          end
        end else if (redirect_i) begin
          kill_d = 1'b1;
          pc_d   = target;
        end
      end
      StHold: begin
        if (redirect_i) begin
          instr_valid_d = 1'b0;
          pc_d          = target;
          state_d       = StReq;
        end else if (instr_ready_i) begin
          instr_valid_d = 1'b0;
          state_d       = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StReq;
      pc_q          <= RESET_PC & 32'hFFFF_FFFC;
      req_pc_q      <= '0;
      kill_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= Nop;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      kill_q        <= kill_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  assign imem_req_o    = (state_q == StReq) && !reset;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = instr_valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios plus a randomized run against a
// transaction-level model of the PC, the single outstanding fetch, and the decode slot.
module tb_instr_fetch_ctrl;

  localparam logic [31:0] ResetPc = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i = 1'b0;

  int n_run = 0;
  int n_fail = 0;

  // Model: next fetch pc, one outstanding fetch (address + still wanted?), decode slot.
  logic [31:0] m_pc = ResetPc;
  logic        m_out = 1'b0;
  logic [31:0] m_out_addr = '0;
  logic        m_live = 1'b0;
  logic        m_hold = 1'b0;
  logic [31:0] m_hold_pc = '0;
  logic        m_req = 1'b1;

  instr_fetch_ctrl #(.RESET_PC(ResetPc)) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Drive one cycle of inputs, advance the model, and return at the following negedge.
  // rvalid is only ever asserted when a fetch is actually outstanding.
  task automatic drive(input logic g, input logic rv, input logic rdy, input logic rd,
                       input logic rst, input logic [31:0] tgt);
    logic rv_eff;
    logic grant;
    rv_eff = rv && m_out && !rst;
    grant  = m_req && g && !rst;
    reset         = rst;
    imem_gnt_i    = g;
    imem_rvalid_i = rv_eff;
    imem_rdata_i  = rv_eff ? mem_word(m_out_addr) : $urandom;
    instr_ready_i = rdy;
    redirect_i    = rd;
    redirect_pc_i = tgt;
    if (rst) begin
      m_pc = ResetPc; m_out = 1'b0; m_live = 1'b0; m_hold = 1'b0; m_req = 1'b1;
    end else begin
      if (m_hold && (rd || rdy)) m_hold = 1'b0;
      if (rv_eff) begin
        m_out = 1'b0;
        if (m_live && !rd) begin
          m_hold    = 1'b1;
          m_hold_pc = m_out_addr;
        end
      end else if (m_out && rd) begin
        m_live = 1'b0;
      end
      if (grant) begin
        m_out      = 1'b1;
        m_out_addr = m_pc;
        m_live     = !rd;
      end
      if (rd) m_pc = {tgt[31:2], 2'b00};
      else if (grant) m_pc = m_pc + 32'd4;
      m_req = !m_out && !m_hold;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
  endtask

  task automatic test_reset();
    do_reset();
    n_run++;
    if (imem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_req_forced: got %b expected 0", imem_req_o);
    end
    n_run++;
    if (instr_valid_o !== 1'b0 || instr_o !== 32'h13 || instr_pc_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_instr: got v=%b i=%h pc=%h expected v=0 i=00000013 pc=0",
               instr_valid_o, instr_o, instr_pc_o);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    n_run++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== ResetPc) begin
      n_fail++;
      $display("FAIL reset_first_req: got req=%b addr=%h expected req=1 addr=%h",
               imem_req_o, imem_addr_o, ResetPc);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    n_run++;
    if (instr_valid_o !== 1'b0 || instr_o !== 32'h13 || instr_pc_o !== 32'h0 ||
        imem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midop: got v=%b i=%h pc=%h req=%b expected 0/00000013/0/0",
               instr_valid_o, instr_o, instr_pc_o, imem_req_o);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    n_run++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== ResetPc) begin
      n_fail++;
      $display("FAIL reset_midop_req: got req=%b addr=%h expected 1/%h",
               imem_req_o, imem_addr_o, ResetPc);
    end
  endtask

  task automatic test_stream();
    logic [31:0] got[$];
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      if (instr_valid_o === 1'b1) begin
        got.push_back(instr_pc_o);
        n_run++;
        if (instr_o !== mem_word(instr_pc_o)) begin
          n_fail++;
          $display("FAIL stream_data: got %h expected %h", instr_o, mem_word(instr_pc_o));
        end
      end
    end
    n_run++;
    if (got.size() != 4) begin
      n_fail++; $display("FAIL stream_count: got %0d expected 4", got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_run++;
      if (got[i] !== ResetPc + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL stream_pc%0d: got %h expected %h", i, got[i], ResetPc + 32'(4 * i));
      end
    end
  endtask

  task automatic test_gnt_stall();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      n_run++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h1004) begin
        n_fail++;
        $display("FAIL gnt_stall%0d: got req=%b addr=%h expected 1/00001004",
                 i, imem_req_o, imem_addr_o);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    n_run++;
    if (imem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL gnt_one_outstanding: got req=%b expected 0", imem_req_o);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    n_run++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h1008) begin
      n_fail++;
      $display("FAIL gnt_after: got req=%b addr=%h expected 1/00001008", imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_hold_stall();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      n_run++;
      if (instr_valid_o !== 1'b1 || instr_pc_o !== ResetPc || instr_o !== mem_word(ResetPc) ||
          imem_req_o !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable%0d: got v=%b pc=%h i=%h req=%b expected 1/%h/%h/0",
                 i, instr_valid_o, instr_pc_o, instr_o, imem_req_o, ResetPc, mem_word(ResetPc));
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    n_run++;
    if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h1004) begin
      n_fail++;
      $display("FAIL hold_release: got v=%b req=%b addr=%h expected 0/1/00001004",
               instr_valid_o, imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2002);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    n_run++;
    if (imem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL redir_wait_noreq: got req=%b expected 0", imem_req_o);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    n_run++;
    if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h2000) begin
      n_fail++;
      $display("FAIL redir_wait: got v=%b req=%b addr=%h expected 0/1/00002000",
               instr_valid_o, imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_redirect_hold();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3000);
    n_run++;
    if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h3000) begin
      n_fail++;
      $display("FAIL redir_hold: got v=%b req=%b addr=%h expected 0/1/00003000",
               instr_valid_o, imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_redirect_gnt();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h5000);
    n_run++;
    if (imem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL redir_gnt_wait: got req=%b expected 0", imem_req_o);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4000);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    n_run++;
    if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h4000) begin
      n_fail++;
      $display("FAIL redir_gnt: got v=%b req=%b addr=%h expected 0/1/00004000",
               instr_valid_o, imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE);
    n_run++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_redir: got req=%b addr=%h expected 1/fffffffc", imem_req_o, imem_addr_o);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    n_run++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_instr: got v=%b pc=%h expected 1/fffffffc", instr_valid_o, instr_pc_o);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    n_run++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_next: got req=%b addr=%h expected 1/00000000", imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_random();
    logic rst;
    logic rd;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = !m_out && ($urandom_range(0, 199) == 0);
      rd  = ($urandom_range(0, 7) == 0);
      drive(1'($urandom), 1'($urandom), 1'($urandom), rd, rst, $urandom);
      n_run++;
      if (imem_req_o !== (m_req && !reset)) begin
        n_fail++;
        $display("FAIL rand_req@%0d: got %b expected %b", i, imem_req_o, m_req && !reset);
      end
      if (m_req && !reset) begin
        n_run++;
        if (imem_addr_o !== m_pc) begin
          n_fail++; $display("FAIL rand_addr@%0d: got %h expected %h", i, imem_addr_o, m_pc);
        end
      end
      n_run++;
      if (instr_valid_o !== m_hold) begin
        n_fail++; $display("FAIL rand_valid@%0d: got %b expected %b", i, instr_valid_o, m_hold);
      end
      if (m_hold) begin
        n_run++;
        if (instr_pc_o !== m_hold_pc || instr_o !== mem_word(m_hold_pc)) begin
          n_fail++;
          $display("FAIL rand_instr@%0d: got pc=%h i=%h expected pc=%h i=%h",
                   i, instr_pc_o, instr_o, m_hold_pc, mem_word(m_hold_pc));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_gnt_stall();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_redirect_gnt();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
